// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing the HEX3..HEX0 display between a background value and two requesters.
// Define HEX_LEADING_BLANK_EN to register a leading-zero blank mask alongside hex_value.
module hex_display_arbiter #(
  parameter int DWELL_CYCLES = 25000000,
  parameter int CNT_W        = 25
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [15:0] hps_value,
  input  logic        req_a,
  input  logic [15:0] data_a,
  output logic        gnt_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  output logic        gnt_b,
  output logic [15:0] hex_value,
  output logic [3:0]  digit_blank,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW_A = 2'd1,
    SHOW_B = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             last_b_r;
  logic             avail_s;
  logic             arb_a_s;
  logic             arb_b_s;
  logic [15:0]      hex_next_s;

  // Arbitration decision and next display value, valid whenever the display is free.
  always_comb begin
    arb_a_s    = 1'b0;
    arb_b_s    = 1'b0;
    hex_next_s = hps_value;
    avail_s    = (state_r == IDLE) || (cnt_r == {CNT_W{1'b0}});
    if (req_a && req_b) begin
      if (last_b_r) begin
        arb_a_s = 1'b1;
      end else begin
        arb_b_s = 1'b1;
      end
    end else if (req_a) begin
      arb_a_s = 1'b1;
    end else if (req_b) begin
      arb_b_s = 1'b1;
    end else begin
      arb_a_s = 1'b0;
      arb_b_s = 1'b0;
    end
    if (arb_a_s) begin
      hex_next_s = data_a;
    end else if (arb_b_s) begin
      hex_next_s = data_b;
    end else begin
      hex_next_s = hps_value;
    end
  end

  // Display FSM: grants, dwell countdown and registered display outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      last_b_r  <= 1'b1;
      hex_value <= 16'h0000;
      owner     <= 2'd0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
    end else if (avail_s) begin
      hex_value <= hex_next_s;
      gnt_a     <= arb_a_s;
      gnt_b     <= arb_b_s;
      if (arb_a_s) begin
        state_r  <= SHOW_A;
        owner    <= 2'd1;
        last_b_r <= 1'b0;
        cnt_r    <= DWELL_LOAD;
      end else if (arb_b_s) begin
        state_r  <= SHOW_B;
        owner    <= 2'd2;
        last_b_r <= 1'b1;
        cnt_r    <= DWELL_LOAD;
      end else begin
        state_r  <= IDLE;
        owner    <= 2'd0;
        last_b_r <= last_b_r;
        cnt_r    <= {CNT_W{1'b0}};
      end
    end else begin
      // Mid-dwell: display held, only the counter moves.
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

`ifdef HEX_LEADING_BLANK_EN
  function automatic logic [3:0] lead_blank(input logic [15:0] v);
    logic [3:0] b;
    b[3] = (v[15:12] == 4'h0);
    b[2] = (v[15:8]  == 8'h00);
    b[1] = (v[15:4]  == 12'h000);
    b[0] = 1'b0;
    return b;
  endfunction

  // Blank mask follows hex_value with the same load timing.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      digit_blank <= 4'b0000;
    end else if (avail_s) begin
      digit_blank <= lead_blank(hex_next_s);
    end else begin
      digit_blank <= digit_blank;
    end
  end
`else
  assign digit_blank = 4'b0000;
`endif

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Self-checking bench for hex_display_arbiter: directed scenarios then random traffic against a
// timeline-based reference model (display free again DWELL edges after each grant).
module tb_hex_display_arbiter;

  localparam int DWELL = 4;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b1;
  logic [15:0] hps_value = 16'h1234;
  logic        req_a = 1'b0;
  logic [15:0] data_a = 16'h0000;
  logic        req_b = 1'b0;
  logic [15:0] data_b = 16'h0000;
  logic        gnt_a, gnt_b;
  logic [15:0] hex_value;
  logic [3:0]  digit_blank;
  logic [1:0]  owner;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int          edge_n    = 0;
  int          m_free_at = 0;
  int          m_last    = 2;
  int          m_owner   = 0;
  logic [15:0] m_hex     = 16'h0000;
  logic        m_ga      = 1'b0;
  logic        m_gb      = 1'b0;
  logic [3:0]  m_blank   = 4'b0000;

  hex_display_arbiter #(.DWELL_CYCLES(DWELL), .CNT_W(3)) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .hps_value   (hps_value),
    .req_a       (req_a),
    .data_a      (data_a),
    .gnt_a       (gnt_a),
    .req_b       (req_b),
    .data_b      (data_b),
    .gnt_b       (gnt_b),
    .hex_value   (hex_value),
    .digit_blank (digit_blank),
    .owner       (owner)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [3:0] blank_of(input logic [15:0] v);
    logic [3:0] b = 4'b0000;
    int lz = 0;
    for (int i = 3; i >= 1; i--) begin
      if (v[i*4 +: 4] == 4'h0 && lz == 3 - i) lz++;
    end
    for (int i = 0; i < lz; i++) b[3-i] = 1'b1;
    return b;
  endfunction

  task automatic model_edge();
    int w;
    edge_n++;
    m_ga = 1'b0;
    m_gb = 1'b0;
    if (reset) begin
      m_hex = 16'h0000; m_owner = 0; m_last = 2; m_free_at = edge_n; m_blank = 4'b0000;
    end else if (edge_n >= m_free_at) begin
      w = 0;
      if (req_a && req_b) w = (m_last == 1) ? 2 : 1;
      else if (req_a) w = 1;
      else if (req_b) w = 2;
      if (w == 1) begin
        m_hex = data_a; m_ga = 1'b1; m_owner = 1; m_last = 1; m_free_at = edge_n + DWELL;
      end else if (w == 2) begin
        m_hex = data_b; m_gb = 1'b1; m_owner = 2; m_last = 2; m_free_at = edge_n + DWELL;
      end else begin
        m_hex = hps_value; m_owner = 0;
      end
`ifdef HEX_LEADING_BLANK_EN
      m_blank = blank_of(m_hex);
`else
      m_blank = 4'b0000;
`endif
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, edge_n);
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    model_edge();
    #1;
    chk("hex_value",   hex_value,          m_hex);
    chk("owner",       {14'd0, owner},     m_owner[15:0]);
    chk("gnt_a",       {15'd0, gnt_a},     {15'd0, m_ga});
    chk("gnt_b",       {15'd0, gnt_b},     {15'd0, m_gb});
    chk("digit_blank", {12'd0, digit_blank}, {12'd0, m_blank});
    chk("gnt_overlap", {15'd0, gnt_a & gnt_b}, 16'h0000);
  endtask

  initial begin
    // Reset with background 1234, then release with no requests
    step(); step();
    reset = 1'b0;
    step(); step();

    // Single A pulse with BEEF, then dwell and return to background
    req_a = 1'b1; data_a = 16'hBEEF;
    step();
    req_a = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Both requesters held from reset: A,B,A,B alternation
    reset = 1'b1; req_a = 1'b1; req_b = 1'b1; data_a = 16'hAAAA; data_b = 16'hBBBB;
    step();
    reset = 1'b0;
    for (int i = 0; i < 17; i++) step();
    req_a = 1'b0; req_b = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // In SHOW_A pulse B mid-dwell, hold A past expiry with new data
    req_a = 1'b1; data_a = 16'h1111;
    step();
    req_a = 1'b0; step();
    req_b = 1'b1; data_b = 16'h2222; step();
    req_b = 1'b0; req_a = 1'b1; data_a = 16'h3333;
    for (int i = 0; i < 3; i++) step();
    req_a = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Reset in 2nd cycle of SHOW_B, both requesting: A first after release
    req_b = 1'b1; data_b = 16'h5555;
    step();
    req_b = 1'b0; step();
    reset = 1'b1; req_a = 1'b1; req_b = 1'b1; data_a = 16'h6666; data_b = 16'h7777;
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();
    req_a = 1'b0; req_b = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Leading-zero blanking on the background path
    hps_value = 16'h0042; step(); step();
    hps_value = 16'h0000; step(); step();
    hps_value = 16'h0F00; step(); step();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      hps_value = 16'($urandom);
      if (!req_a) data_a = 16'($urandom);
      if (!req_b) data_b = 16'($urandom);
      req_a = ($urandom_range(0, 2) == 0);
      req_b = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) begin
        data_a = {8'h00, 8'($urandom)};
        hps_value = {12'h000, 4'($urandom)};
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
